// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default timing constants
// and small helpers, used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_e;

    localparam int unsigned PS2_CLK_HZ      = 100_000_000;
    localparam int unsigned PS2_INHIBIT_CYC = 12_000;
    localparam int unsigned PS2_RTS_CYC     = 100;
    localparam int unsigned PS2_TIMEOUT_CYC = 1_500_000;
    localparam int unsigned PS2_FILTER_LEN  = 8;

    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    function automatic int unsigned ps2_max3(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser plus falling-edge strobe for one PS/2 pad. With
// PS2_TX_GLITCH_FILTER_EN defined, an edge needs 8 consecutive low samples after a high level.
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;

    // Idle bus level is high, so the synchroniser powers up high to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam logic [2:0] LOW_LAST = 3'(PS2_FILTER_LEN - 1);

    logic [2:0] low_cnt_q;
    logic       filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_q <= '0;
            filt_q    <= 1'b1;
        end else if (sync_q) begin
            low_cnt_q <= '0;
            filt_q    <= 1'b1;
        end else if (low_cnt_q == LOW_LAST) begin
            filt_q    <= 1'b0;
        end else begin
            low_cnt_q <= low_cnt_q + 3'd1;
        end
    end

    assign level_o = filt_q;
    assign fall_o  = filt_q & ~sync_q & (low_cnt_q == LOW_LAST);
`else
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;
`endif

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked data/parity/stop,
// ACK check and timeout. Optional macro PS2_TX_GLITCH_FILTER_EN adds a device-clock glitch filter.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ      = PS2_CLK_HZ,
    parameter int unsigned INHIBIT_CYC = PS2_INHIBIT_CYC,
    parameter int unsigned RTS_CYC     = PS2_RTS_CYC,
    parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned CNT_MAX = ps2_max3(INHIBIT_CYC, RTS_CYC, TIMEOUT_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    if (CLK_HZ < 1_000_000 || INHIBIT_CYC == 0 || RTS_CYC == 0 || TIMEOUT_CYC == 0) begin : g_bad_params
        $error("ps2_host_tx: invalid timing parameters");
    end

    logic clk_lvl;
    logic clk_fall;
    logic data_lvl;
    logic data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (ps2_clk_in),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (ps2_data_in),
        .level_o (data_lvl),
        .fall_o  (data_fall_unused)
    );

    ps2_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       data_q;
    logic             parity_q;
    logic             clk_oe_q;
    logic             data_oe_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid && ready_q) begin
                        data_q    <= tx_data;
                        parity_q  <= ps2_odd_parity(tx_data);
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        clk_oe_q  <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        cnt_q     <= '0;
                        data_oe_q <= 1'b1;
                        state_q   <= ST_RTS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RTS: begin
                    // Releasing the clock with data held low is the request-to-send / start bit.
                    if (cnt_q == RTS_LAST) begin
                        cnt_q    <= '0;
                        clk_oe_q <= 1'b0;
                        state_q  <= ST_START;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (clk_fall) begin
                        cnt_q <= '0;
                        case (state_q)
                            ST_START: begin
                                data_oe_q <= ~data_q[0];
                                bit_idx_q <= 3'd1;
                                state_q   <= ST_DATA;
                            end
                            ST_DATA: begin
                                data_oe_q <= ~data_q[bit_idx_q];
                                bit_idx_q <= bit_idx_q + 3'd1;
                                if (bit_idx_q == 3'd7) begin
                                    state_q <= ST_PARITY;
                                end
                            end
                            ST_PARITY: begin
                                data_oe_q <= ~parity_q;
                                state_q   <= ST_STOP;
                            end
                            ST_STOP: begin
                                data_oe_q <= 1'b0;
                                state_q   <= ST_ACK;
                            end
                            ST_ACK: begin
                                if (!data_lvl) begin
                                    state_q <= ST_WAIT_IDLE;
                                end else begin
                                    err_q   <= 1'b1;
                                    ready_q <= 1'b1;
                                    state_q <= ST_IDLE;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else if (state_q == ST_WAIT_IDLE && clk_lvl && data_lvl) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == TMO_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx_ready    = ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: table of byte sends against an open-drain device
// model, plus timeout, mid-frame reset and (with the filter macro) glitch sequences.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    // Timing parameters scaled down so the whole run stays short.
    localparam int INH  = 120;
    localparam int RTS  = 10;
    localparam int TMO  = 1500;
    localparam int HALF = 40;
`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam int SYNC_LAT = 10;
`else
    localparam int SYNC_LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;

    // Open-drain pads: either side pulling low wins.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .RTS_CYC     (RTS),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       ack_low;
        logic       exp_par;
        logic [1:0] exp_pulse;   // {done, err}
    } vec_t;

    vec_t        vt[6];
    logic [1:0]  sb_q[$];
    logic [1:0]  mon_exp;
    int          vecs = 0;
    int          errs = 0;
    int unsigned cyc = 0;
    int unsigned t_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Scoreboard consumer: every done/err pulse must match the oldest expectation.
    always begin
        @(posedge clk);
        #1;
        if (tx_done || tx_err) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 32'({tx_done, tx_err}), 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("pulse_kind", 32'({tx_done, tx_err}), 32'(mon_exp));
            end
        end
    end

    task automatic wait_sb(input string name);
        int guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Host request, then device clocks up to 11 edges; stop_after>0 ends early.
    task automatic run_frame(input logic [7:0] d, input logic ack_low, input int stop_after,
                             input int glitch_edge, output logic [9:0] seen,
                             output int inh_len, output int rts_len);
        int guard = 0;
        seen = '0;
        inh_len = 0;
        rts_len = 0;
        tx_data = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data = 8'h00;
        while (ps2_clk_oe && !ps2_data_oe && guard < 4 * INH) begin
            inh_len++;
            guard++;
            tick();
        end
        while (ps2_clk_oe && ps2_data_oe && guard < 4 * INH) begin
            rts_len++;
            guard++;
            tick();
        end
        check("start_bit", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
        check("busy_ready", 32'(tx_ready), 32'd0);
        repeat (5) tick();
        for (int e = 1; e <= 11; e++) begin
            dev_clk_low = 1'b1;
            if (e == stop_after) t_edge = cyc;
            repeat (HALF) tick();
            if (e <= 10) seen[e-1] = ps2_data_in;
            dev_clk_low = 1'b0;
            if (e == 10 && ack_low) dev_data_low = 1'b1;
            if (e == 11) dev_data_low = 1'b0;
            if (e == glitch_edge) begin
                repeat (15) tick();
                dev_clk_low = 1'b1;
                repeat (3) tick();
                dev_clk_low = 1'b0;
                repeat (HALF - 18) tick();
            end else if (e == 5) begin
                // A request while busy must be ignored.
                tx_data = ~d;
                tx_valid = 1'b1;
                tick();
                tx_valid = 1'b0;
                tx_data = 8'h00;
                repeat (HALF - 1) tick();
            end else begin
                repeat (HALF) tick();
            end
            if (e == stop_after) break;
        end
    endtask

    task automatic table_frame(input vec_t v, input int glitch_edge);
        logic [9:0] seen;
        int inh, rts;
        sb_q.push_back(v.exp_pulse);
        run_frame(v.data, v.ack_low, 0, glitch_edge, seen, inh, rts);
        wait_sb("pulse_seen");
        check("inhibit_len", 32'(inh), 32'(INH));
        check("rts_len", 32'(rts), 32'(RTS));
        check("data_bits", 32'(seen[7:0]), 32'(v.data));
        check("parity_bit", 32'(seen[8]), 32'(v.exp_par));
        check("stop_bit", 32'(seen[9]), 32'd1);
        check("idle_ready", 32'(tx_ready), 32'd1);
        check("idle_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        $display("frame 0x%02h: bits %b parity %b stop %b inhibit %0d rts %0d pulse %b",
                 v.data, seen[7:0], seen[8], seen[9], inh, rts, v.exp_pulse);
    endtask

    initial begin
        logic [9:0] seen;
        int inh, rts, guard;
        vec_t v;

        vt[0] = '{8'hED, 1'b1, 1'b1, 2'b10};
        vt[1] = '{8'hF4, 1'b1, 1'b0, 2'b10};
        vt[2] = '{8'h00, 1'b1, 1'b1, 2'b10};
        vt[3] = '{8'hFF, 1'b1, 1'b1, 2'b10};
        vt[4] = '{8'hA5, 1'b0, 1'b1, 2'b01};
        vt[5] = '{8'h80, 1'b1, 1'b0, 2'b10};

        #2 rst_n = 1'b0;
        #1;
        check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("rst_pulses", 32'({tx_done, tx_err}), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(tx_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            table_frame(vt[i], 0);
        end

        // Device stops clocking after edge 4.
        sb_q.push_back(2'b01);
        run_frame(8'h3C, 1'b1, 4, 0, seen, inh, rts);
        guard = 0;
        while (!tx_err && guard < TMO + 200) begin
            tick();
            guard++;
        end
        check("timeout_latency", 32'(cyc - t_edge), 32'(TMO + SYNC_LAT));
        check("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        wait_sb("timeout_pulse_seen");
        $display("timeout: err after %0d cycles from edge 4", cyc - t_edge);

        // Reset in the middle of DATA; no pulse may follow.
        run_frame(8'h00, 1'b1, 3, 0, seen, inh, rts);
        check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("midrst_pulses", 32'({tx_done, tx_err}), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("midrst_ready", 32'(tx_ready), 32'd1);
        repeat (20) tick();
        $display("reset: frame abandoned mid-data");
        table_frame(vt[0], 0);

`ifdef PS2_TX_GLITCH_FILTER_EN
        v = vt[0];
        table_frame(v, 4);
        $display("glitch: 3-cycle low pulse after edge 4 filtered");
`else
        v = vt[1];
        table_frame(v, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
